// File: rtl/ram_loader_pkg.sv
// Shared encodings for the Mock8080 serial RAM loader: frame FSM states, UART
// receiver states, the SYNC byte and the LEN-to-count helper.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'h55;

    // LEN of zero encodes a full 256-byte page.
    function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
        return (len == 8'h00) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// RAM write port plus loader status, grouped as one bundle between the loader
// (master) and the RAM / CPU reset / debug consumers (slave).
interface ram_loader_if;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output ram_addr, ram_data, ram_we, cpu_hold, busy, done, error);
    modport slave  (input  ram_addr, ram_data, ram_we, cpu_hold, busy, done, error);
endinterface

// File: rtl/ram_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// byte_vld_o / framing_err_o pulse one cycle at mid-stop-bit; no backpressure.
module uart_rx_byte
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_qzt,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       framing_err_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            meta_q, sync_q, prev_q;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            vld_q, vld_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                // A glitch that is gone by mid-start-bit is not a byte.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    st_d   = RX_IDLE;
                    vld_d  = sync_q;
                    ferr_d = ~sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign byte_o        = shift_q;
    assign byte_vld_o    = vld_q;
    assign framing_err_o = ferr_q;

endmodule

// File: rtl/ram_loader.sv
// Frame loader (SYNC ADDR LEN data [CSUM]) into the 256-byte RAM; ram_we 1 cycle after byte_valid,
// no backpressure (UART paces input). Optional trailing checksum under `LOADER_CHECKSUM_EN.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk_qzt,
    input  logic          reset_n,
    input  logic          rx,
    ram_loader_if.master  bus
);

    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW      = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_qzt       (clk_qzt),
        .reset_n       (reset_n),
        .rx_i          (rx),
        .byte_o        (rx_byte),
        .byte_vld_o    (rx_vld),
        .framing_err_o (rx_ferr)
    );

    state_t        state_q, state_d;
    logic [7:0]    ptr_q, ptr_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    ram_addr_q, ram_addr_d;
    logic [7:0]    ram_data_q, ram_data_d;
    logic          ram_we_q, ram_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic mid_frame;
    assign mid_frame = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        // Silence timer restarts on every byte and only runs inside a frame.
        if (!mid_frame || rx_vld)   tmo_d = '0;
        else if (tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
        else                        tmo_d = tmo_q;

        if (mid_frame && (rx_ferr || tmo_q == TMO_LAST)) begin
            state_d = ST_ERR;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_vld && rx_byte == LOADER_SYNC_BYTE) begin
                        state_d = ST_ADDR;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (rx_vld) begin
                        ptr_d   = rx_byte;
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = rx_byte;
`endif
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_vld) begin
                        cnt_d   = len_to_cnt(rx_byte);
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = sum_q + rx_byte;
`endif
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_vld) begin
                        ram_addr_d = ptr_q;
                        ram_data_d = rx_byte;
                        ram_we_d   = 1'b1;
                        ptr_d      = ptr_q + 8'd1;
                        cnt_d      = cnt_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d      = sum_q + rx_byte;
                        if (cnt_q == 9'd1) state_d = ST_CSUM;
`else
                        if (cnt_q == 9'd1) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_vld) begin
                        state_d = (rx_byte == sum_q) ? ST_DONE : ST_ERR;
                        busy_d  = 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    done_d  = 1'b1;
                    error_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_ERR: begin
                    error_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.cpu_hold = busy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: drives 8N1 frames on rx and logs RAM writes.
module tb_ram_loader;

    localparam int CPB = 8;
    localparam int TOB = 20;

    logic clk_qzt = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;

    ram_loader_if bus ();

    ram_loader #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk_qzt (clk_qzt),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #5 clk_qzt = ~clk_qzt;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_mem [256];
    logic [7:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic       prev_we = 1'b0;
    logic       we_double = 1'b0;

    always @(negedge clk_qzt) begin
        if (bus.ram_we === 1'b1) begin
            if (prev_we) we_double = 1'b1;
            wr_mem[bus.ram_addr] = bus.ram_data;
            last_addr = bus.ram_addr;
            last_data = bus.ram_data;
            wr_cnt++;
        end
        prev_we = (bus.ram_we === 1'b1);
    end

    task automatic clear_log();
        for (int i = 0; i < 256; i++) wr_mem[i] = 8'h00;
        wr_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (CPB) @(posedge clk_qzt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk_qzt);
        end
        rx = stop_v;
        repeat (CPB) @(posedge clk_qzt);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk_qzt);
        @(negedge clk_qzt);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_qzt);
        n_cmp++; if ({bus.ram_addr, bus.ram_data} !== 16'h0000) begin n_bad++;
            $display("FAIL reset_addr_data: got %h want 0000", {bus.ram_addr, bus.ram_data}); end
        n_cmp++; if ({bus.ram_we, bus.cpu_hold, bus.busy, bus.done, bus.error} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {bus.ram_we, bus.cpu_hold, bus.busy, bus.done, bus.error}); end
        reset_n = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_basic();
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'h10, 1'b1);
        @(negedge clk_qzt);
        n_cmp++; if (bus.cpu_hold !== 1'b1 || bus.busy !== 1'b1) begin n_bad++;
            $display("FAIL basic_hold_during: got %b%b want 11", bus.cpu_hold, bus.busy); end
        send_byte(8'h03, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h29, 1'b1);
`endif
        idle_bits(1);
        n_cmp++; if (wr_cnt !== 3) begin n_bad++;
            $display("FAIL basic_wr_cnt: got %0d want 3", wr_cnt); end
        n_cmp++; if ({wr_mem[8'h10], wr_mem[8'h11], wr_mem[8'h12]} !== 24'hA1B2C3) begin n_bad++;
            $display("FAIL basic_data: got %h%h%h want A1B2C3", wr_mem[8'h10], wr_mem[8'h11], wr_mem[8'h12]); end
        n_cmp++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin n_bad++;
            $display("FAIL basic_done: got done=%b error=%b want 1/0", bus.done, bus.error); end
        n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++;
            $display("FAIL basic_hold_after: got %b want 0", bus.cpu_hold); end
    endtask

    task automatic test_wrap();
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h07, 1'b1);
`endif
        idle_bits(1);
        n_cmp++; if ({wr_mem[8'hFE], wr_mem[8'hFF], wr_mem[8'h00]} !== 24'h010203) begin n_bad++;
            $display("FAIL wrap_data: got %h%h%h want 010203", wr_mem[8'hFE], wr_mem[8'hFF], wr_mem[8'h00]); end
        n_cmp++; if (last_addr !== 8'h00 || wr_cnt !== 3) begin n_bad++;
            $display("FAIL wrap_last: got addr=%h cnt=%0d want 00/3", last_addr, wr_cnt); end
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++;
            $display("FAIL wrap_done: got %b want 1", bus.done); end
    endtask

    task automatic test_len_zero();
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80, 1'b1);
`endif
        idle_bits(1);
        n_cmp++; if (wr_cnt !== 256) begin n_bad++;
            $display("FAIL len0_wr_cnt: got %0d want 256", wr_cnt); end
        n_cmp++; if (last_addr !== 8'hFF || last_data !== 8'hFF) begin n_bad++;
            $display("FAIL len0_last: got %h=%h want FF=FF", last_addr, last_data); end
        n_cmp++; if (wr_mem[8'h80] !== 8'h80) begin n_bad++;
            $display("FAIL len0_mid: got %h want 80", wr_mem[8'h80]); end
        n_cmp++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin n_bad++;
            $display("FAIL len0_done: got done=%b error=%b want 1/0", bus.done, bus.error); end
    endtask

    task automatic test_noise_and_tail();
        clear_log();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle_bits(2);
        n_cmp++; if (wr_cnt !== 0 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL noise_ignored: got cnt=%0d busy=%b want 0/0", wr_cnt, bus.busy); end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h55, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(1);
        n_cmp++; if (wr_mem[8'h20] !== 8'hAA || wr_cnt !== 1) begin n_bad++;
            $display("FAIL badsum_write: got %h cnt=%0d want AA/1", wr_mem[8'h20], wr_cnt); end
        n_cmp++; if (bus.error !== 1'b1 || bus.done !== 1'b0) begin n_bad++;
            $display("FAIL badsum_flags: got error=%b done=%b want 1/0", bus.error, bus.done); end
`else
        send_byte(8'h55, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle_bits(1);
        n_cmp++; if (wr_mem[8'h10] !== 8'h5A || wr_cnt !== 1) begin n_bad++;
            $display("FAIL nosum_write: got %h cnt=%0d want 5A/1", wr_mem[8'h10], wr_cnt); end
        n_cmp++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin n_bad++;
            $display("FAIL nosum_flags: got done=%b error=%b want 1/0", bus.done, bus.error); end
`endif
    endtask

    task automatic test_framing();
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle_bits(2);
        n_cmp++; if (wr_cnt !== 1 || wr_mem[8'h30] !== 8'h11) begin n_bad++;
            $display("FAIL framing_writes: got cnt=%0d m30=%h want 1/11", wr_cnt, wr_mem[8'h30]); end
        n_cmp++; if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b0) begin n_bad++;
            $display("FAIL framing_flags: got error=%b done=%b hold=%b want 1/0/0", bus.error, bus.done, bus.cpu_hold); end
    endtask

    task automatic test_timeout();
        bit seen;
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_bits(15);
        n_cmp++; if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin n_bad++;
            $display("FAIL timeout_early: got busy=%b error=%b want 1/0", bus.busy, bus.error); end
        seen = 1'b0;
        for (int i = 0; i < 10 * CPB && !seen; i++) begin
            @(negedge clk_qzt);
            if (bus.error === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++;
            $display("FAIL timeout_abort: error stayed %b, want 1 within 25 bit periods", bus.error); end
        n_cmp++; if (bus.cpu_hold !== 1'b0 || bus.done !== 1'b0 || wr_cnt !== 0) begin n_bad++;
            $display("FAIL timeout_state: got hold=%b done=%b cnt=%0d want 0/0/0", bus.cpu_hold, bus.done, wr_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'h55, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        @(negedge clk_qzt);
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({bus.ram_addr, bus.ram_data, bus.ram_we, bus.cpu_hold, bus.busy, bus.done, bus.error} !== 21'h0) begin n_bad++;
            $display("FAIL rstmid_outputs: got %h want 000000", {bus.ram_addr, bus.ram_data, bus.ram_we, bus.cpu_hold, bus.busy, bus.done, bus.error}); end
        repeat (3) @(negedge clk_qzt);
        reset_n = 1'b1;
        idle_bits(12);
        n_cmp++; if (wr_cnt !== 2 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_quiet: got cnt=%0d done=%b error=%b busy=%b want 2/0/0/0", wr_cnt, bus.done, bus.error, bus.busy); end
        send_byte(8'h55, 1'b1);
        send_byte(8'h60, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hD8, 1'b1);
`endif
        idle_bits(1);
        n_cmp++; if (wr_mem[8'h60] !== 8'h77 || wr_cnt !== 3 || bus.done !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_reload: got m60=%h cnt=%0d done=%b want 77/3/1", wr_mem[8'h60], wr_cnt, bus.done); end
    endtask

    task automatic test_we_pulse();
        n_cmp++; if (we_double !== 1'b0) begin n_bad++;
            $display("FAIL we_single_cycle: got back-to-back ram_we=%b want 0", we_double); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_noise_and_tail();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_we_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
